// File: rtl/tmds_frame_sequencer_pkg.sv
// rtl/tmds_frame_sequencer_pkg.sv - shared types, ctrl mapping and default 640x480 timing
package tmds_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } region_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam int CTRL_HSYNC_BIT = 0;
  localparam int CTRL_VSYNC_BIT = 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Blanking-period symbol an encoder emits for a given {c1,c0}.
  function automatic logic [9:0] tmds_ctrl_code(input logic [1:0] ctrl);
    logic [9:0] code;
    case (ctrl)
      2'b00:   code = TMDS_CTRL_00;
      2'b01:   code = TMDS_CTRL_01;
      2'b10:   code = TMDS_CTRL_10;
      default: code = TMDS_CTRL_11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - one raster axis: count, wrap and ACTIVE/FP/SYNC/BP decode
module video_axis_counter
  import tmds_frame_sequencer_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_hold,
  input  logic          i_adv,
  output logic [CW-1:0] o_cnt,
  output logic          o_last,
  output region_e       o_region
);

  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] END_ACT  = CW'(ACTIVE);
  localparam logic [CW-1:0] END_FP   = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] END_SYNC = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_hold) begin
      cnt_d = '0;
    end else if (i_adv) begin
      cnt_d = o_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == LAST);

  always_comb begin
    if (cnt_q < END_ACT) begin
      o_region = REG_ACTIVE;
    end else if (cnt_q < END_FP) begin
      o_region = REG_FP;
    end else if (cnt_q < END_SYNC) begin
      o_region = REG_SYNC;
    end else begin
      o_region = REG_BP;
    end
  end

endmodule

// File: rtl/tmds_frame_sequencer.sv
// rtl/tmds_frame_sequencer.sv - raster timing and pixel scheduler feeding the B/G/R TMDS encoders
module tmds_frame_sequencer
  import tmds_frame_sequencer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [23:0] i_pix_data,
  input  logic        i_pix_sof,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic        o_de,
  output logic [7:0]  o_data_b,
  output logic [7:0]  o_data_g,
  output logic [7:0]  o_data_r,
  output logic [1:0]  o_ctrl_b,
  output logic [1:0]  o_ctrl_g,
  output logic [1:0]  o_ctrl_r,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic        o_sof_err,
  input  logic        i_clr_err
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  seq_state_e    state_q, state_d;
  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last;
  region_e       h_region, v_region;

  logic          de_q, de_d;
  logic [23:0]   data_q, data_d;
  logic [1:0]    ctrl_b_q, ctrl_b_d;
  logic          frame_start_q, frame_start_d;
  logic          underflow_q, underflow_d;
  logic          sof_err_q, sof_err_d;
  logic          accept, first_slot;

  assign run = (state_q == ST_RUN);

  // Counters sit at (0,0) while idle so the first RUN cycle is the frame's first slot.
  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hold   (!run),
    .i_adv    (run),
    .o_cnt    (h_cnt),
    .o_last   (h_last),
    .o_region (h_region)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_hold   (!run),
    .i_adv    (run && h_last),
    .o_cnt    (v_cnt),
    .o_last   (v_last),
    .o_region (v_region)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Enable is only honoured on frame boundaries so a frame is never truncated.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_en) state_d = ST_RUN;
      ST_RUN:  if (h_last && v_last && !i_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pix_ready = run && !i_rst && (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
    accept      = o_pix_ready && i_pix_valid;
    first_slot  = (h_cnt == '0) && (v_cnt == '0);

    de_d          = o_pix_ready;
    data_d        = accept ? i_pix_data : 24'h0;
    frame_start_d = o_pix_ready && first_slot;

    ctrl_b_d                 = 2'b00;
    ctrl_b_d[CTRL_HSYNC_BIT] = (run && h_region == REG_SYNC) ? H_POL : !H_POL;
    ctrl_b_d[CTRL_VSYNC_BIT] = (run && v_region == REG_SYNC) ? V_POL : !V_POL;

    // A new event in the clearing cycle keeps the flag set.
    underflow_d = (o_pix_ready && !i_pix_valid) || (underflow_q && !i_clr_err);
    sof_err_d   = (accept && (first_slot ? !i_pix_sof : i_pix_sof)) ||
                  (sof_err_q && !i_clr_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_q          <= 1'b0;
      data_q        <= 24'h0;
      ctrl_b_q      <= {!V_POL, !H_POL};
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      de_q          <= de_d;
      data_q        <= data_d;
      ctrl_b_q      <= ctrl_b_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      sof_err_q     <= sof_err_d;
    end
  end

  assign o_de          = de_q;
  assign o_data_b      = data_q[7:0];
  assign o_data_g      = data_q[15:8];
  assign o_data_r      = data_q[23:16];
  assign o_ctrl_b      = ctrl_b_q;
  assign o_ctrl_g      = 2'b00;
  assign o_ctrl_r      = 2'b00;
  assign o_frame_start = frame_start_q;
  assign o_underflow   = underflow_q;
  assign o_sof_err     = sof_err_q;

endmodule

// File: tb/tb_tmds_frame_sequencer.sv
// tb/tb_tmds_frame_sequencer.sv - directed self-checking bench on an 8x6 raster
module tb_tmds_frame_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst, i_en, i_pix_sof, i_pix_valid, i_clr_err;
  logic [23:0] i_pix_data;
  logic        o_pix_ready, o_de, o_frame_start, o_underflow, o_sof_err;
  logic [7:0]  o_data_b, o_data_g, o_data_r;
  logic [1:0]  o_ctrl_b, o_ctrl_g, o_ctrl_r;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  tmds_frame_sequencer #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_pix_data    (i_pix_data),
    .i_pix_sof     (i_pix_sof),
    .i_pix_valid   (i_pix_valid),
    .o_pix_ready   (o_pix_ready),
    .o_de          (o_de),
    .o_data_b      (o_data_b),
    .o_data_g      (o_data_g),
    .o_data_r      (o_data_r),
    .o_ctrl_b      (o_ctrl_b),
    .o_ctrl_g      (o_ctrl_g),
    .o_ctrl_r      (o_ctrl_r),
    .o_frame_start (o_frame_start),
    .o_underflow   (o_underflow),
    .o_sof_err     (o_sof_err),
    .i_clr_err     (i_clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {o_de, o_ctrl_b, o_pix_ready, o_frame_start, o_data_r, o_data_g, o_data_b},
        {1'b0, 2'b11, 1'b0, 1'b0, 24'h0});
  endtask

  // Runs one 48-slot frame starting at slot (0,0); t = v*8 + h.
  task automatic run_frame(input int miss_t, input bit sof_swap, input int clr_at,
                           input int drop_at, input int rst_at, input int exp_acc);
    int acc = 0;
    for (int t = 0; t < 48; t++) begin
      int h = t % 8;
      int v = t / 8;
      bit exp_rdy = (h < 4) && (v < 3);
      i_pix_valid = (t != miss_t);
      i_pix_sof   = sof_swap ? (t == 8) : (t == 0);
      i_pix_data  = {8'(t + 1), 8'(t ^ 32'h5a), 8'(3 * t)};
      i_clr_err   = (t == clr_at);
      if (t == drop_at) i_en = 1'b0;
      if (t == rst_at) i_rst = 1'b1;
      #1;
      if (t == rst_at) begin
        chk("rst_ready", o_pix_ready, 0);
        step();
        i_rst     = 1'b0;
        i_clr_err = 1'b0;
        chk("rst_outs", {o_de, o_data_r, o_data_g, o_data_b, o_ctrl_b, o_frame_start,
                         o_underflow, o_sof_err, o_pix_ready},
            {1'b0, 24'h0, 2'b11, 4'b0000});
        return;
      end
      chk("ready", o_pix_ready, exp_rdy);
      if (o_pix_ready && i_pix_valid) acc++;
      step();
      chk("de", o_de, exp_rdy);
      chk("data", {o_data_r, o_data_g, o_data_b},
          (exp_rdy && i_pix_valid) ? i_pix_data : 24'h0);
      chk("ctrl_b", o_ctrl_b, {v != 4, !(h == 5 || h == 6)});
      chk("ctrl_gr", {o_ctrl_g, o_ctrl_r}, 4'h0);
      chk("frame_start", o_frame_start, t == 0);
    end
    i_clr_err = 1'b0;
    chk("accepts", acc, exp_acc);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_en        = 1'b0;
    i_pix_valid = 1'b0;
    i_pix_sof   = 1'b0;
    i_clr_err   = 1'b0;
    i_pix_data  = 24'h0;
    step();
    chk_idle("reset_outs");
    chk("reset_flags", {o_underflow, o_sof_err}, 2'b00);
    step();
    i_rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step();
      chk_idle("idle_outs");
      chk("idle_flags", {o_underflow, o_sof_err}, 2'b00);
    end

    // Continuous running: back-to-back frames, frame_start every 48 clocks.
    i_en = 1'b1;
    #1;
    chk("ready_before_run", o_pix_ready, 0);
    step();
    run_frame(-1, 1'b0, -1, -1, -1, 12);
    run_frame(-1, 1'b0, -1, -1, -1, 12);
    chk("clean_flags", {o_underflow, o_sof_err}, 2'b00);

    // Underflow at slot (h=1,v=2), sticky until cleared.
    run_frame(17, 1'b0, -1, -1, -1, 11);
    chk("underflow_set", o_underflow, 1);
    run_frame(-1, 1'b0, 5, -1, -1, 12);
    chk("underflow_clr", o_underflow, 0);

    // SOF on (0,1) instead of (0,0); clear coincides with the second error.
    run_frame(-1, 1'b1, 8, -1, -1, 12);
    chk("sof_err_set_wins", o_sof_err, 1);
    chk("sof_no_underflow", o_underflow, 0);
    run_frame(-1, 1'b0, 2, -1, -1, 12);
    chk("sof_err_clr", o_sof_err, 0);

    // Enable dropped mid-frame: frame completes, then idle.
    run_frame(-1, 1'b0, -1, 10, -1, 12);
    for (int i = 0; i < 6; i++) begin
      chk_idle("post_drop_idle");
      step();
    end

    // Reset mid-frame with both sticky flags set beforehand.
    i_en = 1'b1;
    step();
    run_frame(1, 1'b1, -1, -1, 20, 0);
    step();
    run_frame(-1, 1'b0, -1, -1, -1, 12);
    chk("final_flags", {o_underflow, o_sof_err}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
